// File: rtl/memory_arbiter_if.sv
// Cache/RAM bundle for memory_arbiter.
// Macro: none. Parameters WORD_W (data width) and ADDR_W (address width).
// Cache side: iREN/iaddr, dREN/dWEN/daddr/dstore in; iwait/dwait/iload/dload back.
// RAM side:   ramREN/ramWEN/ramaddr/ramstore out; ramload/ramstate back.
// Status:     memerr, sticky grant-timeout flag.
// slave  = the arbiter's view; master = the caches + RAM (testbench) view.
interface memory_arbiter_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              iwait;
    logic              dwait;
    logic [WORD_W-1:0] iload;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              memerr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates icache fetches and dcache reads/writes onto one RAM
// port, returns iwait/dwait/iload/dload, and flags grants that never see ACCESS.
// Optional macro ARB_ROUND_ROBIN_EN: conflicts go to the requester not served
// last; without it data always beats instruction.
// Ports: CLK (rising edge), nRST (async active-low), bus (memory_arbiter_if.slave).
// Parameters: WORD_W, ADDR_W (must match the interface), TIMEOUT (>=1).
module memory_arbiter #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           CLK,
    input  logic           nRST,
    memory_arbiter_if.slave bus
);

    // Timer only needs to reach TIMEOUT-1 before the abort fires.
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               memerr_q, memerr_d;
    logic               dreq;
    logic               access;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        LG_INSTR = 1'b0,
        LG_DATA  = 1'b1
    } last_e;

    last_e              last_q, last_d;
`endif

    assign dreq       = bus.dREN | bus.dWEN;
    assign access     = (bus.ramstate == RAM_ACCESS);
    assign bus.memerr = memerr_q;

    // State, timer and sticky error registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            memerr_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= LG_INSTR;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            memerr_q <= memerr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    // Next state plus the combinational cache/RAM-side responses.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        memerr_d     = memerr_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d       = last_q;
`endif
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = WORD_W'(0);
        bus.dload    = WORD_W'(0);
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = ADDR_W'(0);
        bus.ramstore = WORD_W'(0);

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (dreq && bus.iREN) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = (last_q == LG_DATA) ? GRANT_I : GRANT_D;
`else
                    state_d = GRANT_D;
`endif
                end else if (dreq) begin
                    state_d = GRANT_D;
                end else if (bus.iREN) begin
                    state_d = GRANT_I;
                end
            end

            GRANT_D: begin
                if (!dreq) begin
                    // Request withdrawn: strobes already low, quietly return.
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = bus.dREN & ~bus.dWEN;
                    bus.ramstore = bus.dstore;
                    if (access) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                        state_d   = IDLE;
                        timer_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d    = LG_DATA;
`endif
                    end else if (timer_q == TMR_LAST) begin
                        memerr_d = 1'b1;
                        state_d  = IDLE;
                        timer_d  = '0;
                    end else begin
                        timer_d = TMR_W'(timer_q + 1'b1);
                    end
                end
            end

            GRANT_I: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    bus.ramaddr = bus.iaddr;
                    bus.ramREN  = 1'b1;
                    if (access) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        state_d   = IDLE;
                        timer_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d    = LG_INSTR;
`endif
                    end else if (timer_q == TMR_LAST) begin
                        memerr_d = 1'b1;
                        state_d  = IDLE;
                        timer_d  = '0;
                    end else begin
                        timer_d = TMR_W'(timer_q + 1'b1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected hits into a queue,
// a negedge monitor pops and compares whenever iwait or dwait drops.
module tb_memory_arbiter;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic clk;
    logic nrst;

    memory_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    memory_arbiter #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every hit pulse must match the next queued expectation.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] got;
        if (nrst && (!bus.iwait || !bus.dwait)) begin
            checks++;
            if (!bus.iwait && !bus.dwait) begin
                errors++;
                $display("FAIL hit_both: iwait=0 dwait=0, expected a single hit");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL hit_unexpected: iwait=%b dwait=%b ramaddr=0x%08h, expected no hit",
                         bus.iwait, bus.dwait, bus.ramaddr);
            end else begin
                e   = exp_q.pop_front();
                got = e.wr ? bus.ramstore : (e.is_d ? bus.dload : bus.iload);
                if ((!bus.dwait) !== e.is_d || bus.ramaddr !== e.addr || got !== e.data ||
                    (e.wr && bus.ramWEN !== 1'b1) || (!e.wr && bus.ramREN !== 1'b1)) begin
                    errors++;
                    $display("FAIL hit_data: got d=%b addr=0x%08h data=0x%08h ren=%b wen=%b, expected d=%b addr=0x%08h data=0x%08h wr=%b",
                             !bus.dwait, bus.ramaddr, got, bus.ramREN, bus.ramWEN,
                             e.is_d, e.addr, e.data, e.wr);
                end
            end
        end
    end

    initial begin
        nrst         = 1'b0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;

        // Reset state
        #8;
        chk("rst_iwait",  32'(bus.iwait),  32'd1);
        chk("rst_dwait",  32'(bus.dwait),  32'd1);
        chk("rst_ramren", 32'(bus.ramREN), 32'd0);
        chk("rst_ramwen", 32'(bus.ramWEN), 32'd0);
        chk("rst_memerr", 32'(bus.memerr), 32'd0);
        chk("rst_addr",   bus.ramaddr,     32'h0);
        #4 nrst = 1'b1;

        // Instruction fetch, hit on first grant cycle
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        bus.ramstate = ACCESS; bus.ramload = 32'h8C220004;
        push(1'b0, 1'b0, 32'h40, 32'h8C220004);
        settle();
        chk("if_idle_iwait",  32'(bus.iwait),  32'd1);
        chk("if_idle_ramren", 32'(bus.ramREN), 32'd0);
        step(); settle();
        chk("if_grant_addr",  bus.ramaddr,     32'h40);
        chk("if_grant_ramren",32'(bus.ramREN), 32'd1);
        chk("if_grant_iwait", 32'(bus.iwait),  32'd0);
        chk("if_grant_iload", bus.iload,       32'h8C220004);
        step();
        bus.iREN = 1'b0;
        settle();
        chk("if_after_iwait", 32'(bus.iwait),  32'd1);
        chk("if_after_ramren",32'(bus.ramREN), 32'd0);

        // Conflicts: write wins first; second conflict depends on arbitration mode
        step();
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD;
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramload = 32'h11111111;
        push(1'b1, 1'b1, 32'h100, 32'hDEAD);
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b0, 1'b0, 32'h44, 32'h11111111);
        push(1'b1, 1'b0, 32'h104, 32'h11111111);
`else
        push(1'b1, 1'b0, 32'h104, 32'h11111111);
        push(1'b0, 1'b0, 32'h44, 32'h11111111);
`endif
        step(); settle();
        chk("cf_wr_ramwen", 32'(bus.ramWEN), 32'd1);
        chk("cf_wr_ramren", 32'(bus.ramREN), 32'd0);
        chk("cf_wr_addr",   bus.ramaddr,     32'h100);
        chk("cf_wr_store",  bus.ramstore,    32'hDEAD);
        chk("cf_wr_dwait",  32'(bus.dwait),  32'd0);
        chk("cf_wr_iwait",  32'(bus.iwait),  32'd1);
        step();
        bus.dWEN = 1'b0; bus.dREN = 1'b1; bus.daddr = 32'h104;
        settle();
        chk("cf_gap_iwait",  32'(bus.iwait),  32'd1);
        chk("cf_gap_dwait",  32'(bus.dwait),  32'd1);
        chk("cf_gap_ramren", 32'(bus.ramREN), 32'd0);
        step(); settle();
`ifdef ARB_ROUND_ROBIN_EN
        chk("cf2_first_addr", bus.ramaddr, 32'h44);
`else
        chk("cf2_first_addr", bus.ramaddr, 32'h104);
`endif
        step();
`ifdef ARB_ROUND_ROBIN_EN
        bus.iREN = 1'b0;
`else
        bus.dREN = 1'b0;
`endif
        settle();
        chk("cf2_gap_ramren", 32'(bus.ramREN), 32'd0);
        step(); settle();
`ifdef ARB_ROUND_ROBIN_EN
        chk("cf2_second_addr", bus.ramaddr, 32'h104);
`else
        chk("cf2_second_addr", bus.ramaddr, 32'h44);
`endif
        step();
        bus.dREN = 1'b0; bus.iREN = 1'b0;

        // RAM busy for three grant cycles, then ACCESS
        step();
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        bus.ramstate = BUSY; bus.ramload = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            chk("busy_dwait",  32'(bus.dwait),  32'd1);
            chk("busy_addr",   bus.ramaddr,     32'h200);
            chk("busy_ramren", 32'(bus.ramREN), 32'd1);
        end
        step();
        bus.ramstate = ACCESS;
        push(1'b1, 1'b0, 32'h200, 32'hCAFEF00D);
        settle();
        chk("busy_hit_dwait", 32'(bus.dwait), 32'd0);
        chk("busy_hit_dload", bus.dload,      32'hCAFEF00D);
        step();
        bus.dREN = 1'b0;
        settle();
        chk("busy_memerr", 32'(bus.memerr), 32'd0);

        // Timeout: four BUSY grant cycles abort, error is sticky, retry completes
        step();
        bus.dREN = 1'b1; bus.daddr = 32'h300;
        bus.ramstate = BUSY; bus.ramload = 32'h5A5A5A5A;
        for (int i = 0; i < 4; i++) begin
            step(); settle();
            chk("to_grant_dwait",  32'(bus.dwait),  32'd1);
            chk("to_grant_ramren", 32'(bus.ramREN), 32'd1);
            chk("to_grant_memerr", 32'(bus.memerr), 32'd0);
        end
        step(); settle();
        chk("to_abort_ramren", 32'(bus.ramREN), 32'd0);
        chk("to_abort_dwait",  32'(bus.dwait),  32'd1);
        chk("to_abort_memerr", 32'(bus.memerr), 32'd1);
        step();
        bus.ramstate = ACCESS;
        push(1'b1, 1'b0, 32'h300, 32'h5A5A5A5A);
        settle();
        chk("to_retry_dwait",  32'(bus.dwait),  32'd0);
        chk("to_retry_memerr", 32'(bus.memerr), 32'd1);
        step();
        bus.dREN = 1'b0; bus.ramstate = FREE;

        // Requester withdraws in its second grant cycle
        step();
        bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = BUSY;
        step(); settle();
        chk("drop_g1_ramren", 32'(bus.ramREN), 32'd1);
        step();
        bus.dREN = 1'b0;
        settle();
        chk("drop_g2_ramren", 32'(bus.ramREN), 32'd0);
        chk("drop_g2_dwait",  32'(bus.dwait),  32'd1);
        chk("drop_g2_addr",   bus.ramaddr,     32'h0);
        step(); settle();
        chk("drop_idle_ramren", 32'(bus.ramREN), 32'd0);
        chk("drop_memerr_held", 32'(bus.memerr), 32'd1);

        // Reset asserted mid-grant drops strobes at once and clears memerr
        step();
        bus.iREN = 1'b1; bus.iaddr = 32'h500;
        step(); settle();
        chk("rstg_ramren", 32'(bus.ramREN), 32'd1);
        #1 nrst = 1'b0;
        #1;
        chk("rstg_async_ramren", 32'(bus.ramREN), 32'd0);
        chk("rstg_async_addr",   bus.ramaddr,     32'h0);
        chk("rstg_memerr",       32'(bus.memerr), 32'd0);
        bus.iREN = 1'b0;
        step();
        nrst = 1'b1;
        step(); settle();
        chk("rstg_after_iwait", 32'(bus.iwait), 32'd1);

        step();
        chk("pending_hits", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
